// File: rtl/mod_mul_il_ctrl_if.sv
// Request, multiplier-drive and result signals of the modular-multiply controller.
// Every valid/ready pair transfers on a clock edge where both are high; valid is held with stable data until then.
interface mod_mul_il_ctrl_if #(
    parameter int NBITS = 128,
    parameter int PBITS = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NBITS-1:0]       in_a;
    logic [NBITS-1:0]       in_b;
    logic [NBITS-1:0]       in_m;
    logic                   mul_enable_p;
    logic [NBITS-1:0]       mul_a;
    logic [NBITS-1:0]       mul_b;
    logic [NBITS-1:0]       mul_m;
    logic [NBITS+PBITS-1:0] mul_mx3;
    logic [NBITS-1:0]       mul_y;
    logic                   mul_done_p;
    logic                   res_valid;
    logic                   res_ready;
    logic [NBITS-1:0]       res_y;
    logic                   res_err;

    modport slave (
        input  in_valid, in_a, in_b, in_m, mul_y, mul_done_p, res_ready,
        output in_ready, mul_enable_p, mul_a, mul_b, mul_m, mul_mx3, res_valid, res_y, res_err
    );

    modport master (
        output in_valid, in_a, in_b, in_m, mul_y, mul_done_p, res_ready,
        input  in_ready, mul_enable_p, mul_a, mul_b, mul_m, mul_mx3, res_valid, res_y, res_err
    );
endinterface

// File: rtl/mod_mul_il_ctrl.sv
// Sequencing controller for an external interleaved modular multiplier (IDLE/PREP/ISSUE/WAIT/RESP).
// Optional operand range check enabled by defining MOD_MUL_IL_CTRL_RANGE_CHK_EN.
module mod_mul_il_ctrl #(
    parameter int NBITS = 128,
    parameter int PBITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mod_mul_il_ctrl_if.slave     bus,
    output logic [2:0]           state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   ready_q;
    logic [NBITS-1:0]       a_q;
    logic [NBITS-1:0]       b_q;
    logic [NBITS-1:0]       m_q;
    logic [NBITS+PBITS-1:0] mx3_q;
    logic [NBITS+PBITS-1:0] m_ext;
    logic [NBITS-1:0]       y_q;
    logic                   accept;
    logic                   range_bad;

    assign accept = bus.in_valid & ready_q;
    // Headroom bits make 3*m exact for any NBITS-bit modulus.
    assign m_ext  = {{PBITS{1'b0}}, m_q};

`ifdef MOD_MUL_IL_CTRL_RANGE_CHK_EN
    logic err_q;
    assign range_bad   = (m_q == '0) || (a_q >= m_q) || (b_q >= m_q);
    assign bus.res_err = err_q;
`else
    assign range_bad   = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PREP;
            PREP:    state_d = range_bad ? RESP : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.mul_done_p) state_d = RESP;
            RESP:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            mx3_q   <= '0;
            y_q     <= '0;
`ifdef MOD_MUL_IL_CTRL_RANGE_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
                m_q <= bus.in_m;
            end
            if (state_q == PREP) begin
                mx3_q <= (m_ext << 1) + m_ext;
            end
            if (state_q == WAIT && bus.mul_done_p) begin
                y_q <= bus.mul_y;
`ifdef MOD_MUL_IL_CTRL_RANGE_CHK_EN
                err_q <= 1'b0;
`endif
            end
`ifdef MOD_MUL_IL_CTRL_RANGE_CHK_EN
            if (state_q == PREP && range_bad) begin
                y_q   <= '0;
                err_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.in_ready     = ready_q;
    assign bus.mul_enable_p = (state_q == ISSUE);
    assign bus.mul_a        = a_q;
    assign bus.mul_b        = b_q;
    assign bus.mul_m        = m_q;
    assign bus.mul_mx3      = mx3_q;
    assign bus.res_valid    = (state_q == RESP);
    assign bus.res_y        = y_q;
    assign state            = state_q;
endmodule

// File: tb/tb_mod_mul_il_ctrl.sv
// Directed bench for mod_mul_il_ctrl at NBITS=8; the multiplier is stubbed with hand-computed results.
// Inputs change and outputs are sampled on the falling edge.
module tb_mod_mul_il_ctrl;
    localparam int NB = 8;
    localparam int PB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    mod_mul_il_ctrl_if #(.NBITS(NB), .PBITS(PB)) bus ();

    mod_mul_il_ctrl #(.NBITS(NB), .PBITS(PB)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
    );

    // ---------------- driver tasks ----------------
    task automatic do_accept(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m, output bit ok);
        bus.in_a = a;
        bus.in_b = b;
        bus.in_m = m;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.in_ready === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_enable(output int k);
        k = 0;
        while (bus.mul_enable_p !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pulse_done(input logic [7:0] y);
        bus.mul_y = y;
        bus.mul_done_p = 1'b1;
        @(negedge clk);
        bus.mul_done_p = 1'b0;
        bus.mul_y = ~y;
    endtask

    task automatic take_result();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    // Full request through the stub multiplier, with latency, drive and result checks.
    task automatic run_mul(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                           input logic [7:0] exp_y, input logic [9:0] exp_mx3);
        bit ok;
        int k;
        do_accept(a, b, m, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s accept: in_ready never high", name); end
        wait_enable(k);
        n_cmp++;
        if (k + 1 !== 2) begin n_err++; $display("FAIL %s latency: got %0d expected 2", name, k + 1); end
        n_cmp++;
        if ({bus.mul_a, bus.mul_b, bus.mul_m, bus.mul_mx3} !== {a, b, m, exp_mx3}) begin
            n_err++;
            $display("FAIL %s drive: got a=%0d b=%0d m=%0d mx3=%0d expected %0d %0d %0d %0d", name,
                     bus.mul_a, bus.mul_b, bus.mul_m, bus.mul_mx3, a, b, m, exp_mx3);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.mul_enable_p !== 1'b0 || state !== 3'd3) begin
            n_err++;
            $display("FAIL %s pulse: got en=%b state=%0d expected 0/3", name, bus.mul_enable_p, state);
        end
        repeat (2) @(negedge clk);
        pulse_done(exp_y);
        n_cmp++;
        if ({bus.res_valid, bus.res_y, bus.res_err, state} !== {1'b1, exp_y, 1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL %s result: got v=%b y=%0d err=%b st=%0d expected 1 %0d 0 4", name,
                     bus.res_valid, bus.res_y, bus.res_err, state, exp_y);
        end
        take_result();
        n_cmp++;
        if ({bus.res_valid, bus.in_ready, state} !== {1'b0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL %s release: got v=%b rdy=%b st=%0d expected 0 1 0", name,
                     bus.res_valid, bus.in_ready, state);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.mul_enable_p, bus.res_valid, bus.res_y, bus.res_err, state} !== '0 ||
            {bus.mul_a, bus.mul_b, bus.mul_m, bus.mul_mx3} !== '0) begin
            n_err++;
            $display("FAIL reset_vals: got rdy=%b en=%b v=%b y=%0d err=%b st=%0d expected all 0",
                     bus.in_ready, bus.mul_enable_p, bus.res_valid, bus.res_y, bus.res_err, state);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_early: got %b expected 0", bus.in_ready); end
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_ready_rise: got rdy=%b st=%0d expected 1 0", bus.in_ready, state);
        end
    endtask

    task automatic test_vectors();
        run_mul("basic", 8'd5, 8'd7, 8'd11, 8'd2, 10'd33);
        run_mul("ten_ten", 8'd10, 8'd10, 8'd11, 8'd1, 10'd33);
        run_mul("a_zero", 8'd0, 8'd9, 8'd11, 8'd0, 10'd33);
        run_mul("mx3_max", 8'd3, 8'd4, 8'd255, 8'd12, 10'd765);
    endtask

    task automatic test_backpressure();
        bit ok;
        int k;
        do_accept(8'd5, 8'd7, 8'd11, ok);
        wait_enable(k);
        @(negedge clk);
        pulse_done(8'd2);
        bus.in_a = 8'd1; bus.in_b = 8'd2; bus.in_m = 8'd3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({bus.res_valid, bus.res_y, bus.in_ready} !== {1'b1, 8'd2, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b y=%0d rdy=%b expected 1 2 0", i,
                         bus.res_valid, bus.res_y, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hs_ready: got %b expected 0", bus.in_ready); end
        @(negedge clk);
        bus.res_ready = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_after_hs: got rdy=%b v=%b expected 1 0", bus.in_ready, bus.res_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (state !== 3'd1 || bus.mul_a !== 8'd1) begin
            n_err++;
            $display("FAIL bp_next_accept: got st=%0d a=%0d expected 1 1", state, bus.mul_a);
        end
        wait_enable(k);
        @(negedge clk);
        pulse_done(8'd2);
        take_result();
    endtask

    task automatic test_spurious_done();
        bit ok;
        bus.mul_done_p = 1'b1;
        @(negedge clk);
        bus.mul_done_p = 1'b0;
        n_cmp++;
        if (state !== 3'd0 || bus.res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL spur_idle: got st=%0d v=%b expected 0 0", state, bus.res_valid);
        end
        do_accept(8'd3, 8'd5, 8'd7, ok);
        bus.mul_done_p = 1'b1;
        @(negedge clk);
        bus.mul_done_p = 1'b0;
        n_cmp++;
        if (state !== 3'd2 || bus.mul_enable_p !== 1'b1 || bus.mul_mx3 !== 10'd21) begin
            n_err++;
            $display("FAIL spur_prep: got st=%0d en=%b mx3=%0d expected 2 1 21", state, bus.mul_enable_p, bus.mul_mx3);
        end
        @(negedge clk);
        pulse_done(8'd1);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_y !== 8'd1) begin
            n_err++;
            $display("FAIL spur_result: got v=%b y=%0d expected 1 1", bus.res_valid, bus.res_y);
        end
        take_result();
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int k;
        do_accept(8'd5, 8'd7, 8'd11, ok);
        wait_enable(k);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.mul_enable_p, bus.res_valid, bus.res_y, bus.res_err, state} !== '0 ||
            {bus.mul_a, bus.mul_b, bus.mul_m, bus.mul_mx3} !== '0) begin
            n_err++;
            $display("FAIL midwait_reset: got st=%0d y=%0d a=%0d mx3=%0d expected all 0",
                     state, bus.res_y, bus.mul_a, bus.mul_mx3);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midwait_ready: got %b expected 1", bus.in_ready); end
        run_mul("post_rst", 8'd9, 8'd4, 8'd11, 8'd3, 10'd33);
    endtask

    task automatic test_range_chk();
`ifdef MOD_MUL_IL_CTRL_RANGE_CHK_EN
        bit ok;
        logic [7:0] av[2] = '{8'd12, 8'd0};
        logic [7:0] mv[2] = '{8'd11, 8'd0};
        for (int t = 0; t < 2; t++) begin
            do_accept(av[t], 8'd3, mv[t], ok);
            n_cmp++;
            if (bus.mul_enable_p !== 1'b0) begin n_err++; $display("FAIL rc_prep_en[%0d]: got 1 expected 0", t); end
            @(negedge clk);
            n_cmp++;
            if ({bus.res_valid, bus.res_y, bus.res_err, bus.mul_enable_p, state} !== {1'b1, 8'd0, 1'b1, 1'b0, 3'd4}) begin
                n_err++;
                $display("FAIL rc_result[%0d]: got v=%b y=%0d err=%b en=%b st=%0d expected 1 0 1 0 4", t,
                         bus.res_valid, bus.res_y, bus.res_err, bus.mul_enable_p, state);
            end
            take_result();
        end
        run_mul("rc_good_after", 8'd5, 8'd7, 8'd11, 8'd2, 10'd33);
`else
        run_mul("no_rc", 8'd12, 8'd3, 8'd11, 8'd3, 10'd33);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_m = '0;
        bus.mul_y = '0;
        bus.mul_done_p = 1'b0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_spurious_done();
        test_reset_mid_wait();
        test_range_chk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mod_mul_il_ctrl.md
MOD_MUL_IL_CTRL -- requirements
Module: mod_mul_il_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 128: operand width.
REQ-002 SHALL have parameter PBITS, default 2: extra headroom bits on mul_mx3.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-006 SHALL have ports in_a, in_b, in_m, each input, NBITS bits: request operands.
REQ-007 SHALL have ports mul_enable_p (output, 1), mul_a, mul_b, mul_m (outputs, NBITS) and mul_mx3 (output, NBITS+PBITS): multiplier drive.
REQ-008 SHALL have ports mul_y (input, NBITS) and mul_done_p (input, 1): multiplier result and one-cycle completion pulse.
REQ-009 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_y (output, NBITS) and res_err (output, 1): result handshake.

Function
REQ-010 SHALL implement FSM states IDLE, PREP, ISSUE, WAIT and RESP.
REQ-011 SHALL assert in_ready only in IDLE; in_valid&in_ready registers in_a/in_b/in_m; IDLE->PREP.
REQ-012 SHALL in PREP register mx3 = 2*m + m, zero-extended to NBITS+PBITS bits with no truncation; PREP->ISSUE after exactly 1 cycle.
REQ-013 SHALL in ISSUE drive mul_enable_p=1 for exactly one cycle; ISSUE->WAIT.
REQ-014 SHALL drive mul_a/mul_b/mul_m/mul_mx3 from registers, held stable from PREP exit until the next accept.
REQ-015 SHALL in WAIT, on mul_done_p=1, capture mul_y into res_y, set res_err=0 and move to RESP.
REQ-016 SHALL ignore mul_done_p in every state except WAIT.
REQ-017 SHALL assert res_valid only in RESP, holding res_y/res_err stable until res_valid&res_ready; then RESP->IDLE.
REQ-018 SHALL keep in_ready low in the RESP handshake cycle; the next request is accepted no earlier than the following cycle.
REQ-019 SHALL give accept-to-mul_enable_p latency of exactly 2 cycles, and mul_done_p-to-res_valid latency of exactly 1 cycle.
REQ-020 SHALL handle a=0 like any other value: issue the multiplier and wait for mul_done_p.

Reset
REQ-021 SHALL, on rst=1 (asynchronous, any state, including mid-WAIT), force state IDLE and clear every output and register to 0.
REQ-022 Reset values SHALL be in_ready=0, mul_enable_p=0, res_valid=0, res_y=0, res_err=0, and mul_a/mul_b/mul_m/mul_mx3=0.
REQ-023 SHALL raise in_ready the first clock edge after rst deasserts.

Configuration
REQ-024 SHALL support macro MOD_MUL_IL_CTRL_RANGE_CHK_EN.
REQ-025 With the macro defined, PREP SHALL check m!=0, a<m and b<m.
REQ-026 With the macro defined and the check failing, PREP SHALL go directly to RESP with res_y=0 and res_err=1, with no mul_enable_p issued.
REQ-027 With the macro undefined, no check logic SHALL exist and res_err SHALL be tied to 0.

Verification
REQ-028 NBITS=8, a=5, b=7, m=11 -> mul_mx3=33, mul_enable_p 2 cycles after accept, res_y=2, res_err=0.
REQ-029 NBITS=8, a=10, b=10, m=11 -> res_y=1; NBITS=8, a=0, b=9, m=11 -> res_y=0 after mul_done_p.
REQ-030 res_ready held low 5 cycles in RESP -> res_valid stays 1 with res_y unchanged; in_valid=1 throughout -> in_ready=0 until the cycle after the handshake.
REQ-031 Spurious mul_done_p in IDLE and PREP -> no state change; rst pulse mid-WAIT -> all outputs 0 and state IDLE, and a new request completes correctly.
REQ-032 Macro defined, a=12, m=11 -> res_err=1, res_y=0, no mul_enable_p; m=0 -> same; macro undefined -> res_err always 0.
REQ-033 NBITS=8, m=255 -> mul_mx3=765, with no overflow in the 10-bit field.
